// File: rtl/tile_stream_reader_if.sv
// Command, BRAM read-port and output-stream bundle for tile_stream_reader.
// master is the reader itself; slave is the scheduler / BRAM / consumer side.
// cfg_stride exists only when TILE_READER_STRIDE_EN is defined.
interface tile_stream_reader_if #(
  parameter int W     = 32,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  // Command side
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_len;
`ifdef TILE_READER_STRIDE_EN
  logic [AW-1:0] cfg_stride;
`endif
  logic          busy;
  logic          done;

  // BRAM read port
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [W-1:0]  bram_rdata;

  // Output stream
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;

`ifdef TILE_READER_STRIDE_EN
  modport master (
    input  start, cfg_base, cfg_len, cfg_stride, bram_rdata, m_ready,
    output busy, done, bram_re, bram_raddr, m_valid, m_data, m_last
  );
  modport slave (
    output start, cfg_base, cfg_len, cfg_stride, bram_rdata, m_ready,
    input  busy, done, bram_re, bram_raddr, m_valid, m_data, m_last
  );
`else
  modport master (
    input  start, cfg_base, cfg_len, bram_rdata, m_ready,
    output busy, done, bram_re, bram_raddr, m_valid, m_data, m_last
  );
  modport slave (
    output start, cfg_base, cfg_len, bram_rdata, m_ready,
    input  busy, done, bram_re, bram_raddr, m_valid, m_data, m_last
  );
`endif
endinterface

// File: rtl/tile_stream_reader.sv
// Purpose: reads a run of tile-BRAM words and streams them out over valid/ready.
// Latency: start accepted in cycle 0 -> bram_re in cycle 1 -> first m_valid in cycle 3.
// Backpressure: 3-entry output FIFO; reads stall once buffered + in-flight words reach 3.
// Optional feature: TILE_READER_STRIDE_EN adds a latched cfg_stride address increment.
module tile_stream_reader #(
  parameter int W     = 32,
  parameter int DEPTH = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  tile_stream_reader_if.master bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // (a + b) mod DEPTH for operands already below DEPTH
  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_L) s = s - DEPTH_L;
    return s[AW-1:0];
  endfunction

  // a mod DEPTH for an AW-bit value (only matters when DEPTH is not a power of two)
  function automatic logic [AW-1:0] red_mod(input logic [AW-1:0] a);
    logic [AW:0] s;
    s = {1'b0, a};
    if (s >= DEPTH_L) s = s - DEPTH_L;
    return s[AW-1:0];
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issued_q, issued_d;
  logic [AW-1:0] addr_q, addr_d;      // address of the next read to issue
  logic [AW-1:0] step_q, step_d;
  logic          re_q, re_d;
  logic          re_last_q, re_last_d; // read in flight carries word len-1
  logic [AW-1:0] raddr_q, raddr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // BRAM data is valid the cycle after re; vld_q marks that cycle
  logic          vld_q, vld_last_q;
  logic [W-1:0]  fifo_dat_q [3];
  logic [2:0]    fifo_last_q;
  logic [1:0]    wr_ptr_q, rd_ptr_q, cnt_q;

  logic          m_valid, pop, head_last, credit_ok;
  logic [2:0]    occ_next;
  logic [AW:0]   len_c;
  logic [AW-1:0] base_c, step_c;

  assign m_valid   = (cnt_q != 2'd0);
  assign pop       = m_valid && bus.m_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  // FIFO occupancy after this edge; a new read may issue only if it still fits
  // alongside the word landing next cycle, so the unconditional write never overflows.
  assign occ_next  = {1'b0, cnt_q} + {2'b0, vld_q} - {2'b0, pop};
  assign credit_ok = (occ_next + {2'b0, re_q}) < 3'd3;

  assign len_c  = (bus.cfg_len > DEPTH_L) ? DEPTH_L : bus.cfg_len;
  assign base_c = red_mod(bus.cfg_base);
`ifdef TILE_READER_STRIDE_EN
  assign step_c = red_mod(bus.cfg_stride);
`else
  assign step_c = AW'(1);
`endif

  // Burst FSM: command acceptance, read issue with credit check, drain and done
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    addr_d    = addr_q;
    step_d    = step_q;
    re_d      = 1'b0;
    re_last_d = 1'b0;
    raddr_d   = raddr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            len_d     = len_c;
            step_d    = step_c;
            re_d      = 1'b1;
            raddr_d   = base_c;
            re_last_d = (len_c == (AW+1)'(1));
            addr_d    = add_mod(base_c, step_c);
            issued_d  = (AW+1)'(1);
            busy_d    = 1'b1;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          re_d      = 1'b1;
          raddr_d   = addr_q;
          re_last_d = (issued_q == len_q - (AW+1)'(1));
          addr_d    = add_mod(addr_q, step_q);
          issued_d  = issued_q + (AW+1)'(1);
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      addr_q    <= '0;
      step_q    <= '0;
      re_q      <= 1'b0;
      re_last_q <= 1'b0;
      raddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      addr_q    <= addr_d;
      step_q    <= step_d;
      re_q      <= re_d;
      re_last_q <= re_last_d;
      raddr_q   <= raddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Read-latency stage and 3-entry output FIFO; reset drops any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      vld_last_q  <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      cnt_q       <= 2'd0;
      fifo_last_q <= '0;
      for (int i = 0; i < 3; i++) fifo_dat_q[i] <= '0;
    end else begin
      vld_q      <= re_q;
      vld_last_q <= re_last_q;
      if (vld_q) begin
        fifo_dat_q[wr_ptr_q]  <= bus.bram_rdata;
        fifo_last_q[wr_ptr_q] <= vld_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= occ_next[1:0];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bram_re    = re_q;
  assign bus.bram_raddr = raddr_q;
  assign bus.m_valid    = m_valid;
  // Head is gated so the stream reads zero whenever nothing is buffered
  assign bus.m_data     = m_valid ? fifo_dat_q[rd_ptr_q] : '0;
  assign bus.m_last     = m_valid && head_last;
endmodule

// File: tb/tb_tile_stream_reader.sv
// Randomized bench for tile_stream_reader with a queue-based reference model.
// Model derives the address/word sequence of each accepted burst from its config.
// Directed bursts pin the model with literal addresses, data and cycle numbers.
module tb_tile_stream_reader;
  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_stream_reader_if #(.W(W), .DEPTH(DEPTH)) bus ();
  tile_stream_reader #(.W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Tile BRAM: registered read, one cycle latency
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.bram_re) bus.bram_rdata <= mem[bus.bram_raddr];

  // Consumer ready: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low
  int ready_mode = 0;
  int rcnt = 0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      case (ready_mode)
        1:       bus.m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        2:       bus.m_ready = 1'($urandom_range(0, 1));
        3:       bus.m_ready = 1'b0;
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  // Reference model state and logs
  int           exp_addr[$];
  logic [W:0]   exp_word[$];   // {last, data}
  bit           m_busy, m_done_now, nxt_busy, nxt_done;
  bit           stall_prev;
  logic [W-1:0] prev_data;
  logic         prev_last;
  int           outstanding, max_out;
  int           acc_len, acc_base, acc_stride, acc_a;
  logic [W:0]   e;
  int           re_log[$], re_cyc[$], hs_cyc[$], done_cyc[$];
  logic [W-1:0] hs_data[$];
  bit           hs_last[$];

  // Per-cycle compare against the model, then advance the model for the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr.delete(); exp_word.delete();
      m_busy = 0; m_done_now = 0; stall_prev = 0; outstanding = 0;
    end else begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done_now);
      if (bus.done) done_cyc.push_back(cyc);
      nxt_busy = m_busy;
      nxt_done = 0;
      if (bus.bram_re) begin
        re_log.push_back(int'(bus.bram_raddr));
        re_cyc.push_back(cyc);
        chk("read_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("bram_raddr", bus.bram_raddr, exp_addr.pop_front());
        outstanding++;
      end
      if (stall_prev) begin
        chk("valid_held", bus.m_valid, 1);
        chk("data_held", bus.m_data, prev_data);
        chk("last_held", bus.m_last, prev_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        hs_data.push_back(bus.m_data);
        hs_last.push_back(bus.m_last);
        hs_cyc.push_back(cyc);
        chk("word_expected", exp_word.size() > 0, 1);
        if (exp_word.size() > 0) begin
          e = exp_word.pop_front();
          chk("m_data", bus.m_data, e[W-1:0]);
          chk("m_last", bus.m_last, e[W]);
          if (e[W]) begin nxt_busy = 0; nxt_done = 1; end
        end
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (bus.bram_re) chk("outstanding_le_3", outstanding <= 3, 1);
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.start && !m_busy) begin
        acc_len  = int'(bus.cfg_len);
        if (acc_len > DEPTH) acc_len = DEPTH;
        acc_base = int'(bus.cfg_base) % DEPTH;
`ifdef TILE_READER_STRIDE_EN
        acc_stride = int'(bus.cfg_stride) % DEPTH;
`else
        acc_stride = 1;
`endif
        if (acc_len == 0) nxt_done = 1;
        else begin
          nxt_busy = 1;
          for (int k = 0; k < acc_len; k++) begin
            acc_a = (acc_base + k * acc_stride) % DEPTH;
            exp_addr.push_back(acc_a);
            exp_word.push_back({k == acc_len - 1, mem[acc_a]});
          end
        end
      end
      m_busy     = nxt_busy;
      m_done_now = nxt_done;
    end
  end

  int t0;

  task automatic clear_logs();
    re_log.delete(); re_cyc.delete(); hs_cyc.delete(); done_cyc.delete();
    hs_data.delete(); hs_last.delete(); max_out = 0;
  endtask

  task automatic start_burst(input int base, input int len, input int stride);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.cfg_base = base[AW-1:0];
    bus.cfg_len  = len[AW:0];
`ifdef TILE_READER_STRIDE_EN
    bus.cfg_stride = stride[AW-1:0];
`else
    if (stride < 0) bus.cfg_base = '0;
`endif
    t0 = cyc;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.cfg_base = AW'($urandom);
    bus.cfg_len  = (AW+1)'($urandom);
`ifdef TILE_READER_STRIDE_EN
    bus.cfg_stride = AW'($urandom);
`endif
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (done_cyc.size() < n && k < budget) begin @(negedge clk); #1; k++; end
    chk("done_within_budget", done_cyc.size() >= n, 1);
    chk("all_words_delivered", exp_word.size(), 0);
    chk("all_reads_issued", exp_addr.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_bram_re"}, bus.bram_re, 0);
    chk({tag, "_bram_raddr"}, bus.bram_raddr, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
  endtask

  int t_first, rlen, rbase;

  initial begin
    bus.start = 1'b0; bus.cfg_base = '0; bus.cfg_len = '0; bus.bram_rdata = '0;
`ifdef TILE_READER_STRIDE_EN
    bus.cfg_stride = '0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
    repeat (3) @(posedge clk);
    #2 chk_zero("reset");
    rst_n = 1'b1;

    // Basic burst with exact timing, then a back-to-back start in the done cycle
    clear_logs(); ready_mode = 0;
    start_burst(10, 4, 1);
    t_first = t0;
    while (cyc < t_first + 7) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.cfg_base = 10'd40; bus.cfg_len = 11'd1;
`ifdef TILE_READER_STRIDE_EN
    bus.cfg_stride = 10'd1;
`endif
    @(posedge clk); #1 bus.start = 1'b0;
    wait_dones(2, 60);
    chk("basic_words", hs_data.size(), 5);
    for (int i = 0; i < 4; i++) begin
      chk("basic_data", hs_data[i], 32'(10 + i));
      chk("basic_last", hs_last[i], i == 3);
      chk("basic_hs_cycle", hs_cyc[i], 32'(t_first + 3 + i));
    end
    chk("basic_first_re_cycle", re_cyc[0], 32'(t_first + 1));
    chk("basic_done_cycle", done_cyc[0], 32'(t_first + 7));
    chk("b2b_second_re_cycle", re_cyc[4], 32'(t_first + 8));
    chk("b2b_second_data", hs_data[4], 32'd40);
    chk("b2b_done_cycle", done_cyc[1], 32'(t_first + 11));

    // Address wrap
    clear_logs();
    start_burst(1022, 4, 1);
    wait_dones(1, 60);
    chk("wrap_reads", re_log.size(), 4);
    chk("wrap_a0", re_log[0], 1022);
    chk("wrap_a1", re_log[1], 1023);
    chk("wrap_a2", re_log[2], 0);
    chk("wrap_a3", re_log[3], 1);
    chk("wrap_d2", hs_data[2], 0);

    // Zero length
    clear_logs();
    start_burst(5, 0, 1);
    wait_dones(1, 20);
    chk("zero_done_cycle", done_cyc[0], 32'(t0 + 1));
    repeat (3) @(posedge clk);
    chk("zero_no_reads", re_log.size(), 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    // Toggling backpressure
    clear_logs(); ready_mode = 1;
    start_burst(77, 8, 1);
    wait_dones(1, 100);
    chk("bp_words", hs_data.size(), 8);

    // Full stall: exactly three reads outstanding, then resume
    clear_logs(); ready_mode = 3;
    start_burst(300, 8, 1);
    repeat (12) @(posedge clk);
    chk("stall_reads", re_log.size(), 3);
    chk("stall_max_outstanding", max_out, 3);
    ready_mode = 0;
    wait_dones(1, 100);
    chk("stall_words", hs_data.size(), 8);

    // Start while busy is ignored
    clear_logs(); ready_mode = 3;
    start_burst(200, 6, 1);
    repeat (2) @(posedge clk);
    start_burst(500, 3, 2);
    ready_mode = 0;
    wait_dones(1, 100);
    chk("ign_reads", re_log.size(), 6);
    chk("ign_first", re_log[0], 200);
    chk("ign_last", re_log[5], 205);

    // Length above DEPTH clamps to DEPTH
    clear_logs(); ready_mode = 0;
    start_burst(7, 1100, 1);
    wait_dones(1, 1300);
    chk("clamp_words", hs_data.size(), DEPTH);
    chk("clamp_last_addr", re_log[DEPTH-1], 6);

`ifdef TILE_READER_STRIDE_EN
    clear_logs();
    start_burst(4, 3, 3);
    wait_dones(1, 60);
    chk("stride_a0", re_log[0], 4);
    chk("stride_a1", re_log[1], 7);
    chk("stride_a2", re_log[2], 10);
    clear_logs();
    start_burst(9, 3, 0);
    wait_dones(1, 60);
    chk("stride0_a2", re_log[2], 9);
`endif

    // Reset in the middle of a burst
    clear_logs(); ready_mode = 0;
    start_burst(100, 16, 1);
    begin
      int k = 0;
      while (hs_data.size() < 2 && k < 50) begin @(negedge clk); k++; end
    end
    chk("midreset_two_words_seen", hs_data.size() >= 2, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    start_burst(0, 2, 1);
    wait_dones(1, 50);
    repeat (4) @(posedge clk);
    chk("post_reset_words", hs_data.size(), 2);
    chk("post_reset_d0", hs_data[0], mem[0]);
    chk("post_reset_d1", hs_data[1], mem[1]);

    // Randomized bursts
    for (int b = 0; b < 25; b++) begin
      clear_logs();
      ready_mode = $urandom_range(0, 2);
      rlen  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      rbase = $urandom_range(0, DEPTH - 1);
      start_burst(rbase, rlen, $urandom_range(0, DEPTH - 1));
      if (rlen > 3 && $urandom_range(0, 2) == 0) begin
        @(posedge clk);
        start_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 40), 1);
      end
      wait_dones(1, 400);
      chk("rand_word_count", hs_data.size(), rlen);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
